// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - fetch/decode/execute sequencer for the 8-bit MCU.
// Optional illegal-opcode trap enabled by defining CU_ILLEGAL_TRAP_EN.
module cpu_control_unit #(
  parameter logic [7:0] TRAP_VECTOR = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instr_in,
  input  logic       zero_flag,
  output logic       load_pc,
  output logic       inc_pc,
  output logic [7:0] pc_in,
  output logic [7:0] ir_out,
  output logic [7:0] operand_out,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       illegal
);

`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_EXECUTE, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] pc_in_q, pc_in_d;
  logic       inc_pc_q, inc_pc_d;
  logic       acc_load_q, acc_load_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       jmp_q, jmp_d;
  logic       jz_q, jz_d;
  logic       jnz_q, jnz_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;
  logic       trap_d;
  logic [3:0] op_d;

  // Outputs are computed from the next state so they are registered yet line up with that state.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = instr_in;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q[7:4])
          4'd0:                         state_d = S_FETCH;
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
          4'd6:                         state_d = S_OPERAND;
          4'd7:                         state_d = S_HALT;
          default:                      state_d = S_FETCH;
        endcase
      end
      S_OPERAND: begin
        operand_d = instr_in;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase

    op_d       = ir_d[7:4];
    trap_d     = TRAP_EN && (state_d == S_DECODE) && (op_d >= 4'd8);
    inc_pc_d   = (state_d == S_FETCH) || (state_d == S_OPERAND);
    acc_load_d = (state_d == S_EXECUTE) && (op_d >= 4'd1) && (op_d <= 4'd3);
    alu_op_d   = 2'b00;
    if (acc_load_d && op_d == 4'd2) alu_op_d = 2'b01;
    if (acc_load_d && op_d == 4'd3) alu_op_d = 2'b10;
    jmp_d      = ((state_d == S_EXECUTE) && (op_d == 4'd4)) || trap_d;
    jz_d       = (state_d == S_EXECUTE) && (op_d == 4'd5);
    jnz_d      = (state_d == S_EXECUTE) && (op_d == 4'd6);
    halted_d   = (state_d == S_HALT);
    pc_in_d    = trap_d ? TRAP_VECTOR : operand_d;
    illegal_d  = illegal_q | trap_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ir_q       <= 8'h00;
      operand_q  <= 8'h00;
      pc_in_q    <= 8'h00;
      inc_pc_q   <= 1'b0;
      acc_load_q <= 1'b0;
      alu_op_q   <= 2'b00;
      jmp_q      <= 1'b0;
      jz_q       <= 1'b0;
      jnz_q      <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      operand_q  <= operand_d;
      pc_in_q    <= pc_in_d;
      inc_pc_q   <= inc_pc_d;
      acc_load_q <= acc_load_d;
      alu_op_q   <= alu_op_d;
      jmp_q      <= jmp_d;
      jz_q       <= jz_d;
      jnz_q      <= jnz_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  // Conditional jumps resolve against the live zero flag during EXECUTE.
  assign load_pc     = jmp_q | (jz_q & zero_flag) | (jnz_q & ~zero_flag);
  assign inc_pc      = inc_pc_q;
  assign pc_in       = pc_in_q;
  assign ir_out      = ir_q;
  assign operand_out = operand_q;
  assign acc_load    = acc_load_q;
  assign alu_op      = alu_op_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed vector bench for cpu_control_unit with a PC and ROM model.
// Trap checks follow CU_ILLEGAL_TRAP_EN.
module tb_cpu_control_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [7:0] instr_in;
  logic       zero_flag = 1'b0;
  logic       load_pc, inc_pc, acc_load, halted, illegal;
  logic [7:0] pc_in, ir_out, operand_out;
  logic [1:0] alu_op;

  logic [7:0] rom [256];
  logic [7:0] pc;
  int         n_tests = 0;
  int         n_fail = 0;
  int         overlaps = 0;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  cpu_control_unit #(.TRAP_VECTOR(8'hF0)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_in(instr_in), .zero_flag(zero_flag),
    .load_pc(load_pc), .inc_pc(inc_pc), .pc_in(pc_in), .ir_out(ir_out),
    .operand_out(operand_out), .acc_load(acc_load), .alu_op(alu_op),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pc <= 8'h00;
    else if (load_pc) pc <= pc_in;
    else if (inc_pc)  pc <= pc + 8'd1;
  end

  assign instr_in = rom[pc];

  always @(negedge clk) if (load_pc && inc_pc) overlaps++;

  typedef struct {
    logic       run;
    logic       inc;
    logic       load;
    logic       acc;
    logic [1:0] alu;
    logic       halt;
    logic [7:0] ir;
    logic [7:0] opnd;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    run = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic jump_test(input logic [7:0] opc, input logic zf, input logic exp_load);
    clear_rom();
    rom[8'h00] = opc;
    rom[8'h01] = 8'h40;
    rom[8'h02] = 8'h70;
    rom[8'h40] = 8'h70;
    zero_flag = zf;
    do_reset();
    start();
    repeat (3) @(negedge clk);
    check($sformatf("jump_exec_%h_zf%0d", opc, zf), {inc_pc, load_pc, pc_in}, {1'b0, exp_load, 8'h40});
    zero_flag = ~zf;
    #1;
    check($sformatf("jump_flagflip_%h_zf%0d", opc, zf), load_pc, !exp_load);
    zero_flag = zf;
    #1;
    @(negedge clk);
    check($sformatf("jump_next_fetch_%h_zf%0d", opc, zf), pc, exp_load ? 8'h40 : 8'h02);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h10, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h10, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h10, 8'h2A};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h10, 8'h2A};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h20, 8'h2A};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h20, 8'h2A};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 8'h20, 8'h05};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h20, 8'h05};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h70, 8'h05};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h70, 8'h05};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h70, 8'h05};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h70, 8'h05};

    // Reset, idle with run low, then the LDI/ADD/HALT program.
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h2A; rom[2] = 8'h20; rom[3] = 8'h05; rom[4] = 8'h70;
    @(negedge clk);
    check("in_reset_outputs", {load_pc, inc_pc, acc_load, alu_op, halted, illegal, pc_in, ir_out, operand_out},
          '0);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("idle_outputs_%0d", c),
            {load_pc, inc_pc, acc_load, alu_op, halted, illegal, pc_in, ir_out, operand_out}, '0);
    end
    for (int i = 0; i < 13; i++) begin
      run = vecs[i].run;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("prog_vec_%0d", i),
            {inc_pc, load_pc, acc_load, alu_op, halted, ir_out, operand_out},
            {vecs[i].inc, vecs[i].load, vecs[i].acc, vecs[i].alu, vecs[i].halt, vecs[i].ir, vecs[i].opnd});
    end
    run = 1'b0;

    jump_test(8'h50, 1'b1, 1'b1);
    jump_test(8'h50, 1'b0, 1'b0);
    jump_test(8'h60, 1'b0, 1'b1);
    jump_test(8'h60, 1'b1, 1'b0);
    zero_flag = 1'b0;

    // JMP across the 0xFF->0x00 wrap, looping between 0x00 and 0xFE.
    clear_rom();
    rom[8'h00] = 8'h40; rom[8'h01] = 8'hFE;
    rom[8'hFE] = 8'h40; rom[8'hFF] = 8'h00;
    do_reset();
    start();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_fetch_pc_%0d", k), pc, (k % 2 == 0) ? 8'h00 : 8'hFE);
      repeat (3) @(negedge clk);
      check($sformatf("wrap_exec_%0d", k), {load_pc, pc_in}, {1'b1, (k % 2 == 0) ? 8'hFE : 8'h00});
      @(negedge clk);
    end

    // Reset during EXECUTE of ADD.
    clear_rom();
    rom[0] = 8'h20; rom[1] = 8'h05; rom[2] = 8'h70;
    do_reset();
    start();
    repeat (3) @(negedge clk);
    check("add_exec_strobe", {acc_load, alu_op}, {1'b1, 2'b01});
    #2 reset = 1'b0;
    #1;
    check("reset_mid_exec", {acc_load, alu_op, inc_pc, load_pc, ir_out, operand_out, pc_in}, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {inc_pc, load_pc, acc_load, halted}, 4'b0000);

    // Illegal opcode 0x9C at 0x10.
    clear_rom();
    rom[8'h00] = 8'h40; rom[8'h01] = 8'h10;
    rom[8'h10] = 8'h9C; rom[8'h11] = 8'h70; rom[8'hF0] = 8'h70;
    do_reset();
    start();
    repeat (4) @(negedge clk);
    check("illegal_fetch_pc", pc, 8'h10);
    @(negedge clk);
    check("illegal_decode", {load_pc, pc_in, illegal}, TRAP ? {1'b1, 8'hF0, 1'b1} : {1'b0, 8'h10, 1'b0});
    @(negedge clk);
    check("illegal_next_pc", pc, TRAP ? 8'hF0 : 8'h11);
    repeat (2) @(negedge clk);
    check("illegal_sticky_halt", {halted, illegal}, {1'b1, TRAP});

    check("no_load_inc_overlap", overlaps, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Fetch/decode/execute sequencer for the 8-bit MCU. It sits directly upstream of the program counter and drives its `load_pc`, `inc_pc` and `pc_in` inputs. It consumes the instruction byte that program memory returns for the current `pc_out`, and issues accumulator/ALU strobes. It latches the opcode and operand, evaluates conditional jumps against the ALU zero flag, and supports HALT and run-start.

## Interface
- `TRAP_VECTOR`, default 8'hF0: PC target on illegal opcode (used only with the trap feature).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low. Low forces the reset state immediately.
- `run` in 1: start request, sampled in IDLE.
- `instr_in` in 8: program-memory data at current `pc_out`. Combinational ROM, valid the same cycle.
- `zero_flag` in 1: ALU zero flag, sampled in EXECUTE.
- `load_pc` out 1: PC load strobe.
- `inc_pc` out 1: PC increment strobe.
- `pc_in` out 8: PC load value.
- `ir_out` out 8: latched opcode byte.
- `operand_out` out 8: latched operand byte.
- `acc_load` out 1: accumulator write strobe, one cycle.
- `alu_op` out 2: 00 pass operand, 01 add, 10 sub; valid while `acc_load`=1.
- `halted` out 1: high in HALT state.
- `illegal` out 1: sticky illegal-opcode flag. Tied 0 when the trap feature is compiled out.

## Operation
- Opcode is `ir_out[7:4]`. Bits [3:0] are ignored.
  - 0 NOP
  - 1 LDI #imm
  - 2 ADD #imm
  - 3 SUB #imm
  - 4 JMP addr
  - 5 JZ addr
  - 6 JNZ addr
  - 7 HALT
  - 8–F illegal
- Opcodes 1–6 are two-byte (opcode then operand). All others are one-byte.
- States: IDLE, FETCH, DECODE, OPERAND, EXECUTE, HALT.
  - IDLE: all strobes 0. `run`=1 → FETCH.
  - FETCH: `ir_out`←`instr_in`, `inc_pc`=1 → DECODE.
  - DECODE, by opcode:
    - NOP → FETCH.
    - HALT → HALT.
    - Two-byte → OPERAND.
    - Illegal → FETCH, executes as NOP (see Configuration).
  - OPERAND: `operand_out`←`instr_in`, `inc_pc`=1 → EXECUTE.
  - EXECUTE:
    - LDI/ADD/SUB: `acc_load`=1, `alu_op`=00/01/10.
    - JMP: `load_pc`=1.
    - JZ: `load_pc`=`zero_flag`.
    - JNZ: `load_pc`=!`zero_flag`.
    - All → FETCH.
  - HALT: terminal. `halted`=1, no strobes. Exit only via reset; `run` is ignored.
- `pc_in` = `operand_out`, except during a trap load (= `TRAP_VECTOR`).
- `load_pc` and `inc_pc` are never high in the same cycle.
- PC wrap 8'hFF→8'h00 is the PC's concern. Operand fetch across the wrap is legal.
- All strobes are Moore outputs, decoded from state and latched registers. Exceptions: the JZ/JNZ `load_pc` depends combinationally on `zero_flag` in EXECUTE.

## Timing
- Reset values: state IDLE; `ir_out`=0, `operand_out`=0; `load_pc`=0, `inc_pc`=0, `acc_load`=0; `alu_op`=00; `pc_in`=0; `halted`=0; `illegal`=0.
- One-byte instruction: 2 cycles (FETCH, DECODE).
- Two-byte instruction: 4 cycles (FETCH, DECODE, OPERAND, EXECUTE).
- First FETCH is the cycle after `run` is sampled high in IDLE.
- Taken jump: the PC holds the target on the edge ending EXECUTE, and the next FETCH reads the target.
- Reset asserted mid-instruction: immediate return to IDLE and all outputs to reset values. No partial strobe completes.
- `run` held high continuously is legal and only acts in IDLE.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE asserts `load_pc`=1 with `pc_in`=`TRAP_VECTOR`.
  - It also sets `illegal` (sticky until reset).
  - Next state is FETCH.
- Undefined:
  - Illegal opcodes behave exactly as NOP.
  - `illegal` is constant 0.
  - `TRAP_VECTOR` is unused.

## Test plan
- Reset low for 3 cycles, release, `run`=0 for 5 cycles → stays IDLE, all outputs 0. Pulse `run` → `inc_pc` in the following cycle.
- ROM {0x10, 0x2A, 0x20, 0x05, 0x70} → `acc_load` with `alu_op`=00 and `operand_out`=0x2A, then `alu_op`=01 with 0x05. `inc_pc` pulses total 5. `halted`=1 after 10 cycles and stays high regardless of `run`.
- JZ 0x40 with `zero_flag`=1 → `load_pc`=1, `pc_in`=0x40 in EXECUTE. Same with `zero_flag`=0 → no load, sequential fetch. JNZ is checked inversely.
- JMP 0x00 placed at 0xFE/0xFF → operand fetched across the wrap, PC reloads 0x00, loop repeats indefinitely.
- Reset asserted during the EXECUTE of ADD → `acc_load` drops in the same cycle, state is IDLE, `ir_out`=0.
- Opcode 0x9C at address 0x10:
  - With `CU_ILLEGAL_TRAP_EN`: `load_pc`=1 with `pc_in`=0xF0, and `illegal`=1 sticky.
  - Without it: NOP, and the next fetch is from 0x11.
